fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Purpose: read-side controller of the synchronous FIFO. Consumes the write pointer, owns the read pointer and empty flag, fetches words from FIFO storage into a first-word-fall-through (FWFT) output register, and presents them on a valid/ready port.

Interface
REQ-001 SHALL have parameter DEPTH, default 4; storage entries, a power of two, 2 or more.
REQ-002 SHALL have parameter PTR_WIDTH, default $clog2(DEPTH)+1; pointer width including the wrap bit.
REQ-003 SHALL have parameter DATA_WIDTH, default 8; word width.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port w_ptr, input, PTR_WIDTH bits; registered write pointer from the write side.
REQ-007 SHALL have port mem_rdata, input, DATA_WIDTH bits; storage contents at r_addr, combinational read.
REQ-008 SHALL have port flush, input, 1 bit; synchronous discard of all buffered data.
REQ-009 SHALL have port out_ready, input, 1 bit; consumer accepts out_data.
REQ-010 SHALL have port r_ptr, output, PTR_WIDTH bits; read pointer, returned to the write side for the full flag.
REQ-011 SHALL have port r_addr, output, PTR_WIDTH-1 bits; storage read address, equal to r_ptr[PTR_WIDTH-2:0].
REQ-012 SHALL have port empty, output, 1 bit; storage holds no unfetched word.
REQ-013 SHALL have port count, output, PTR_WIDTH bits; unfetched words in storage, range 0..DEPTH.
REQ-014 SHALL have port out_valid, output, 1 bit; the output register holds a word.
REQ-015 SHALL have port out_data, output, DATA_WIDTH bits; the output register contents.

Function
REQ-016 empty SHALL be combinational: (r_ptr == w_ptr), comparing all PTR_WIDTH bits.
REQ-017 count SHALL be (w_ptr - r_ptr) modulo 2^PTR_WIDTH; it SHALL read DEPTH when the pointers differ only in the MSB.
REQ-018 Handshake: a transfer SHALL occur in any cycle where out_valid & out_ready are both 1.
REQ-019 Fetch condition: fetch = ~empty & (~out_valid | out_ready) & ~flush.
REQ-020 On fetch, at the clock edge: out_data <= mem_rdata; out_valid <= 1; r_ptr <= r_ptr + 1, wrapping modulo 2^PTR_WIDTH.
REQ-021 On a transfer without a fetch (and no flush), out_valid SHALL become 0 and out_data SHALL hold its value.
REQ-022 When there is neither a fetch nor a transfer, out_valid, out_data and r_ptr SHALL hold.
REQ-023 Throughput: with storage non-empty and out_ready held at 1, one transfer SHALL occur per cycle with no bubbles.
REQ-024 Latency: when storage and the output register are both empty, a w_ptr increment seen at edge N SHALL produce out_valid=1 after edge N+1.
REQ-025 out_valid/out_data SHALL NOT change while out_valid=1 & out_ready=0, unless flush is asserted.
REQ-026 flush=1 at an edge SHALL set r_ptr <= w_ptr and out_valid <= 0, and SHALL override fetch and transfer in the same cycle.
REQ-027 r_ptr SHALL never advance past w_ptr; advances only occur when empty=0.
REQ-028 Wrap-around: r_addr SHALL return to 0 after DEPTH-1 and r_ptr[PTR_WIDTH-1] SHALL toggle; empty/count SHALL stay correct across the toggle.
REQ-029 A w_ptr change in the same cycle as a fetch SHALL take effect on empty/count in that cycle (combinational), with no lost word.

Reset
REQ-030 While rst_n=0 (asynchronous, no clock needed): r_ptr=0, out_valid=0, out_data=0.
REQ-031 A reset mid-stream SHALL discard the output word immediately; r_ptr=0 SHALL be observed by the write side at once.
REQ-032 After rst_n is released, operation SHALL resume at the first rising edge.

Verification (DEPTH=4, DATA_WIDTH=8)
REQ-033 Reset with w_ptr=0: empty=1, count=0, out_valid=0, r_ptr=0.
REQ-034 FWFT latency: w_ptr 0->1 with storage[0]=0xA5 and out_ready=0 -> out_valid=1, out_data=0xA5, r_ptr=1 one edge later, then held stable.
REQ-035 Streaming: 4 words 0x11..0x44 loaded, w_ptr=4, out_ready=1 -> four consecutive transfers in order; empty=1 after the last fetch.
REQ-036 Wrap: push and pop 10 words -> r_ptr ends at 10 mod 8 = 2 and r_addr=2; count=4 when w_ptr=6 and r_ptr=2.
REQ-037 Back-pressure: out_ready=0 with count=3 -> out_valid stays 1, r_ptr frozen, count stays 3; release out_ready -> in-order drain.
REQ-038 Flush mid-stream with w_ptr=5, r_ptr=2, out_valid=1 -> next cycle r_ptr=5, out_valid=0, empty=1; rst_n pulse mid-stream -> r_ptr=0 and out_valid=0 without a clock edge.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the synchronous FIFO: owns the read pointer and
// empty/count, and prefetches storage into a first-word-fall-through output register.
module fifo_rd_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PTR_WIDTH-1:0]  w_ptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic [PTR_WIDTH-1:0]  r_ptr,
  output logic [PTR_WIDTH-2:0]  r_addr,
  output logic                  empty,
  output logic [PTR_WIDTH-1:0]  count,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned ADDR_WIDTH = PTR_WIDTH - 1;

  logic [PTR_WIDTH-1:0]  r_ptr_q,     r_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;

  logic fetch;
  logic xfer;

  // Storage status is combinational so a same-cycle w_ptr update is seen at once.
  assign empty = (r_ptr_q == w_ptr);
  assign count = w_ptr - r_ptr_q;

  assign xfer  = out_valid_q & out_ready;
  assign fetch = ~empty & (~out_valid_q | out_ready) & ~flush;

  // Flush dominates; a fetch refills the output register even while it drains.
  always_comb begin
    r_ptr_d     = r_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      r_ptr_d     = w_ptr;
      out_valid_d = 1'b0;
    end else if (fetch) begin
      r_ptr_d     = r_ptr_q + PTR_WIDTH'(1);
      out_valid_d = 1'b1;
      out_data_d  = mem_rdata;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      r_ptr_q     <= r_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign r_ptr     = r_ptr_q;
  assign r_addr    = r_ptr_q[ADDR_WIDTH-1:0];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl (DEPTH=4, DATA_WIDTH=8): stimulus pushes
// expected words, a negedge monitor pops and compares on every transfer.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] w_ptr = '0;
  logic [7:0] mem_rdata;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] r_ptr;
  logic [1:0] r_addr;
  logic       empty;
  logic [2:0] count;
  logic       out_valid;
  logic [7:0] out_data;

  logic [7:0] mem [4];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[r_addr];

  fifo_rd_ctrl #(.DEPTH(4), .PTR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .w_ptr(w_ptr), .mem_rdata(mem_rdata),
    .flush(flush), .out_ready(out_ready), .r_ptr(r_ptr), .r_addr(r_addr),
    .empty(empty), .count(count), .out_valid(out_valid), .out_data(out_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-side model: store a word, advance w_ptr, expect it at the output.
  task automatic push(input logic [7:0] d);
    mem[w_ptr[1:0]] = d;
    w_ptr = w_ptr + 3'd1;
    exp_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    w_ptr = '0;
    #1;
    exp_q.delete();
    chk("rst_r_ptr", 32'(r_ptr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 40) begin
      step();
      n++;
    end
    chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_drain_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("mon_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // Reset state before any clock edge
    #1;
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_count", 32'(count), 32'd0);
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_r_ptr", 32'(r_ptr), 32'd0);
    chk("init_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // FWFT latency and hold under back-pressure
    push(8'hA5);
    step();
    chk("fwft_valid", 32'(out_valid), 32'd1);
    chk("fwft_data", 32'(out_data), 32'hA5);
    chk("fwft_r_ptr", 32'(r_ptr), 32'd1);
    chk("fwft_empty", 32'(empty), 32'd1);
    step();
    step();
    chk("fwft_hold_valid", 32'(out_valid), 32'd1);
    chk("fwft_hold_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fwft_taken_valid", 32'(out_valid), 32'd0);
    chk("fwft_taken_q", 32'(exp_q.size()), 32'd0);

    // Streaming four words, no bubbles
    do_reset();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    chk("stream_count_full", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", 32'(out_data), 32'(8'h11 * (i + 1)));
      chk("stream_r_ptr", 32'(r_ptr), 32'(i + 1));
    end
    chk("stream_empty_last", 32'(empty), 32'd1);
    step();
    chk("stream_end_valid", 32'(out_valid), 32'd0);
    chk("stream_q", 32'(exp_q.size()), 32'd0);

    // Wrap-around: ten words through, then count across the MSB toggle
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(8'h50 + 8'(i));
      step();
    end
    wait_drain("wrap");
    chk("wrap_r_ptr", 32'(r_ptr), 32'd2);
    chk("wrap_r_addr", 32'(r_addr), 32'd2);
    out_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    #1;
    chk("wrap_w_ptr", 32'(w_ptr), 32'd6);
    chk("wrap_count4", 32'(count), 32'd4);
    chk("wrap_not_empty", 32'(empty), 32'd0);

    // Back-pressure with three words still in storage
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'hC1);
      chk("bp_r_ptr", 32'(r_ptr), 32'd3);
      chk("bp_count", 32'(count), 32'd3);
      step();
    end
    out_ready = 1'b1;
    wait_drain("bp");
    chk("bp_end_r_ptr", 32'(r_ptr), 32'd6);

    // Flush mid-stream overrides fetch and transfer
    do_reset();
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    step();
    push(8'h65);
    out_ready = 1'b1;
    step();
    chk("pre_flush_r_ptr", 32'(r_ptr), 32'd2);
    chk("pre_flush_w_ptr", 32'(w_ptr), 32'd5);
    chk("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    chk("flush_r_ptr", 32'(r_ptr), 32'd5);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_count", 32'(count), 32'd0);

    // Asynchronous reset mid-stream, then resume
    push(8'h71); push(8'h72);
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    w_ptr = '0;
    #1;
    exp_q.delete();
    chk("async_rst_r_ptr", 32'(r_ptr), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push(8'h81);
    step();
    chk("resume_valid", 32'(out_valid), 32'd1);
    chk("resume_data", 32'(out_data), 32'h81);
    out_ready = 1'b1;
    wait_drain("resume");

    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
